// File: rtl/ca_cmd_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : ca_cmd_framer_if
// Purpose  : Valid/ready CA stream from the command framer to the
//            CA distributor. One CA UI word per beat plus a flag that
//            marks the final UI of its command.
// Signals  : ca_out       - head UI word
//            ca_last_out  - head UI is the last UI of its command
//            ca_valid_out - head UI is valid
//            ca_ready_in  - distributor accepts the head UI
// Modports : master (framer side), slave (distributor side)
// Revision : 1.0 - initial release
// ============================================================================
interface ca_cmd_framer_if #(
  parameter int CA_WIDTH = 14
);
  logic [CA_WIDTH-1:0] ca_out;
  logic                ca_last_out;
  logic                ca_valid_out;
  logic                ca_ready_in;

  modport master (
    output ca_out,
    output ca_last_out,
    output ca_valid_out,
    input  ca_ready_in
  );

  modport slave (
    input  ca_out,
    input  ca_last_out,
    input  ca_valid_out,
    output ca_ready_in
  );
endinterface
`default_nettype wire

// File: rtl/ca_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : ca_cmd_framer
// Purpose  : Front-end of the CA distributor. Samples the host DDR5 CA bus
//            each clk, frames 1-UI and 2-UI commands, checks even parity and
//            commits only complete, parity-clean commands into a FWFT FIFO
//            that feeds the distributor's valid/ready CA input.
// Ports    : clk, rst_n          - clock, async active-low reset
//            enable              - framer enable (low aborts in-flight cmd)
//            par_chk_en          - parity check enable
//            dcs_n, dca, dpar    - host CA bus
//            ca_if (master)      - CA stream to the distributor
//            fifo_level          - FIFO occupancy
//            cmd_count           - committed commands (saturating)
//            par_err_count       - parity drops (saturating)
//            ovf_count           - space drops (saturating)
//            err_sticky, err_clr - sticky error flag and its clear
// Revision : 1.0 - initial release
// ============================================================================
module ca_cmd_framer #(
  parameter int CA_WIDTH   = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  wire logic                          clk,
  input  wire logic                          rst_n,
  input  wire logic                          enable,
  input  wire logic                          par_chk_en,
  input  wire logic                          dcs_n,
  input  wire logic [CA_WIDTH-1:0]           dca,
  input  wire logic                          dpar,
  ca_cmd_framer_if.master                    ca_if,
  output logic [$clog2(FIFO_DEPTH)+1-1:0]    fifo_level,
  output logic [CNT_WIDTH-1:0]               cmd_count,
  output logic [CNT_WIDTH-1:0]               par_err_count,
  output logic [CNT_WIDTH-1:0]               ovf_count,
  output logic                               err_sticky,
  input  wire logic                          err_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] c_DEPTH = LW'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  // Holding register for the first UI of a 2-UI command
  logic [CA_WIDTH-1:0] r_hold_data;
  logic                r_hold_good;

  // FIFO storage: {last, data}
  logic [CA_WIDTH:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [LW-1:0]       r_level;

  logic [CNT_WIDTH-1:0] r_cmd_count;
  logic [CNT_WIDTH-1:0] r_par_err_count;
  logic [CNT_WIDTH-1:0] r_ovf_count;
  logic                 r_err_sticky;

  logic                w_ui_good;
  logic                w_pop;
  logic [LW-1:0]       w_free;
  logic [AW-1:0]       w_wr_ptr1;
  logic                w_push0;
  logic                w_push1;
  logic [CA_WIDTH:0]   w_wdat0;
  logic [CA_WIDTH:0]   w_wdat1;
  logic                w_hold_load;
  logic                w_inc_cmd;
  logic                w_inc_par;
  logic                w_inc_ovf;

  // Even parity over {dca, dpar}; every UI is good when checking is off.
  assign w_ui_good = !par_chk_en || !(^{dca, dpar});

  assign w_pop     = (r_level != '0) && ca_if.ca_ready_in;
  // A pop in the same cycle frees its slot for this cycle's write.
  assign w_free    = c_DEPTH - r_level + {{(LW-1){1'b0}}, w_pop};
  assign w_wr_ptr1 = r_wr_ptr + AW'(1);

  // --------------------------------------------------------------------------
  // Framing FSM: next state, FIFO writes and counter events
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_push0     = 1'b0;
    w_push1     = 1'b0;
    w_wdat0     = '0;
    w_wdat1     = '0;
    w_hold_load = 1'b0;
    w_inc_cmd   = 1'b0;
    w_inc_par   = 1'b0;
    w_inc_ovf   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (enable && !dcs_n) begin
          if (dca[1]) begin
            if (!w_ui_good) begin
              w_inc_par = 1'b1;
            end else if (w_free >= LW'(1)) begin
              w_push0   = 1'b1;
              w_wdat0   = {1'b1, dca};
              w_inc_cmd = 1'b1;
            end else begin
              w_inc_ovf = 1'b1;
            end
          end else begin
            w_hold_load = 1'b1;
            w_state_nxt = ST_SECOND;
          end
        end
      end

      ST_SECOND: begin
        w_state_nxt = ST_IDLE;
        if (enable) begin
          if (!(r_hold_good && w_ui_good)) begin
            w_inc_par = 1'b1;
          end else if (w_free >= LW'(2)) begin
            w_push0   = 1'b1;
            w_push1   = 1'b1;
            w_wdat0   = {1'b0, r_hold_data};
            w_wdat1   = {1'b1, dca};
            w_inc_cmd = 1'b1;
          end else begin
            w_inc_ovf = 1'b1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold_data <= '0;
      r_hold_good <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_hold_load) begin
        r_hold_data <= dca;
        r_hold_good <= w_ui_good;
      end
    end
  end

  // --------------------------------------------------------------------------
  // FWFT FIFO. Storage is not reset: the head is masked while empty and the
  // pointers/level restart on reset, so stale contents never reach the output.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push0) r_mem[r_wr_ptr]  <= w_wdat0;
    if (w_push1) r_mem[w_wr_ptr1] <= w_wdat1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push0) + AW'(w_push1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_level  <= r_level + LW'(w_push0) + LW'(w_push1) - LW'(w_pop);
    end
  end

  assign ca_if.ca_valid_out = (r_level != '0);
  assign {ca_if.ca_last_out, ca_if.ca_out} =
           (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign fifo_level = r_level;

  // --------------------------------------------------------------------------
  // Status counters: an event in the same cycle as err_clr loads 1.
  // --------------------------------------------------------------------------
  function automatic logic [CNT_WIDTH-1:0] f_cnt_next(
    input logic [CNT_WIDTH-1:0] cur,
    input logic                 inc,
    input logic                 clr
  );
    if (inc) begin
      if (clr)       return CNT_WIDTH'(1);
      else if (&cur) return cur;
      else           return cur + CNT_WIDTH'(1);
    end else if (clr) begin
      return '0;
    end else begin
      return cur;
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_count     <= '0;
      r_par_err_count <= '0;
      r_ovf_count     <= '0;
      r_err_sticky    <= 1'b0;
    end else begin
      r_cmd_count     <= f_cnt_next(r_cmd_count,     w_inc_cmd, err_clr);
      r_par_err_count <= f_cnt_next(r_par_err_count, w_inc_par, err_clr);
      r_ovf_count     <= f_cnt_next(r_ovf_count,     w_inc_ovf, err_clr);
      if (w_inc_par || w_inc_ovf) r_err_sticky <= 1'b1;
      else if (err_clr)           r_err_sticky <= 1'b0;
    end
  end

  assign cmd_count     = r_cmd_count;
  assign par_err_count = r_par_err_count;
  assign ovf_count     = r_ovf_count;
  assign err_sticky    = r_err_sticky;

endmodule
`default_nettype wire

// File: tb/tb_ca_cmd_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ca_cmd_framer
// Purpose  : Directed self-checking bench for ca_cmd_framer (CA_WIDTH=14,
//            FIFO_DEPTH=8). Inputs change 1 time unit after the rising
//            edge; outputs are sampled at that same point.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ca_cmd_framer;

  localparam int CAW = 14;
  localparam int DEP = 8;
  localparam int CNW = 16;

  logic            clk;
  logic            rst_n;
  logic            enable;
  logic            par_chk_en;
  logic            dcs_n;
  logic [CAW-1:0]  dca;
  logic            dpar;
  logic [3:0]      fifo_level;
  logic [CNW-1:0]  cmd_count;
  logic [CNW-1:0]  par_err_count;
  logic [CNW-1:0]  ovf_count;
  logic            err_sticky;
  logic            err_clr;

  int n_checks;
  int n_errors;

  ca_cmd_framer_if #(.CA_WIDTH(CAW)) ca_if ();

  ca_cmd_framer #(
    .CA_WIDTH   (CAW),
    .FIFO_DEPTH (DEP),
    .CNT_WIDTH  (CNW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .par_chk_en    (par_chk_en),
    .dcs_n         (dcs_n),
    .dca           (dca),
    .dpar          (dpar),
    .ca_if         (ca_if),
    .fifo_level    (fifo_level),
    .cmd_count     (cmd_count),
    .par_err_count (par_err_count),
    .ovf_count     (ovf_count),
    .err_sticky    (err_sticky),
    .err_clr       (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one UI for one cycle, then return the bus to idle.
  task automatic send_ui(input logic [CAW-1:0] d, input bit good);
    dcs_n = 1'b0;
    dca   = d;
    dpar  = good ? ^d : ~(^d);
    tick();
    dcs_n = 1'b1;
    dca   = '0;
    dpar  = 1'b0;
  endtask

  logic [CAW:0] exp_q [8];

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    par_chk_en  = 1'b1;
    dcs_n       = 1'b1;
    dca         = '0;
    dpar        = 1'b0;
    err_clr     = 1'b0;
    ca_if.ca_ready_in = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    chk_eq("rst_valid", 32'(ca_if.ca_valid_out), 32'd0);
    chk_eq("rst_ca",    32'(ca_if.ca_out),       32'd0);
    chk_eq("rst_last",  32'(ca_if.ca_last_out),  32'd0);
    chk_eq("rst_level", 32'(fifo_level),         32'd0);
    chk_eq("rst_cmd",   32'(cmd_count),          32'd0);
    chk_eq("rst_sticky",32'(err_sticky),         32'd0);
    rst_n  = 1'b1;
    enable = 1'b1;
    ca_if.ca_ready_in = 1'b1;
    tick();

    // ---------------- 1-UI command ----------------
    send_ui(14'h0002, 1'b1);
    chk_eq("1ui_valid", 32'(ca_if.ca_valid_out), 32'd1);
    chk_eq("1ui_ca",    32'(ca_if.ca_out),       32'h0002);
    chk_eq("1ui_last",  32'(ca_if.ca_last_out),  32'd1);
    chk_eq("1ui_cmd",   32'(cmd_count),          32'd1);
    tick();
    chk_eq("1ui_drain", 32'(ca_if.ca_valid_out), 32'd0);

    // ---------------- 2-UI command ----------------
    ca_if.ca_ready_in = 1'b0;
    send_ui(14'h1000, 1'b1);
    chk_eq("2ui_held",  32'(ca_if.ca_valid_out), 32'd0);
    send_ui(14'h2ABC, 1'b1);
    chk_eq("2ui_ca0",   32'(ca_if.ca_out),       32'h1000);
    chk_eq("2ui_last0", 32'(ca_if.ca_last_out),  32'd0);
    chk_eq("2ui_level", 32'(fifo_level),         32'd2);
    chk_eq("2ui_cmd",   32'(cmd_count),          32'd2);
    tick();
    chk_eq("2ui_stall", 32'(ca_if.ca_out),       32'h1000);
    ca_if.ca_ready_in = 1'b1;
    tick();
    chk_eq("2ui_ca1",   32'(ca_if.ca_out),       32'h2ABC);
    chk_eq("2ui_last1", 32'(ca_if.ca_last_out),  32'd1);
    tick();
    chk_eq("2ui_empty", 32'(ca_if.ca_valid_out), 32'd0);

    // ---------------- parity error on UI1 ----------------
    ca_if.ca_ready_in = 1'b0;
    send_ui(14'h1000, 1'b1);
    send_ui(14'h0123, 1'b0);
    chk_eq("par_level",  32'(fifo_level),    32'd0);
    chk_eq("par_cnt",    32'(par_err_count), 32'd1);
    chk_eq("par_sticky", 32'(err_sticky),    32'd1);
    chk_eq("par_cmd",    32'(cmd_count),     32'd2);
    // same command with checking disabled is committed
    par_chk_en = 1'b0;
    send_ui(14'h1000, 1'b1);
    send_ui(14'h0123, 1'b0);
    chk_eq("nopar_level", 32'(fifo_level),    32'd2);
    chk_eq("nopar_cmd",   32'(cmd_count),     32'd3);
    chk_eq("nopar_par",   32'(par_err_count), 32'd1);
    par_chk_en = 1'b1;
    ca_if.ca_ready_in = 1'b1;
    tick();
    tick();
    chk_eq("nopar_drain", 32'(fifo_level), 32'd0);

    // ---------------- err_clr ----------------
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk_eq("clr_cmd",    32'(cmd_count),     32'd0);
    chk_eq("clr_par",    32'(par_err_count), 32'd0);
    chk_eq("clr_ovf",    32'(ovf_count),     32'd0);
    chk_eq("clr_sticky", 32'(err_sticky),    32'd0);

    // ---------------- fill and overflow ----------------
    ca_if.ca_ready_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_ui(CAW'((i + 1) * 16), 1'b1);
      send_ui(CAW'(14'h3000 + i + 1), 1'b1);
      exp_q[2*i]   = {1'b0, CAW'((i + 1) * 16)};
      exp_q[2*i+1] = {1'b1, CAW'(14'h3000 + i + 1)};
    end
    chk_eq("fill_level", 32'(fifo_level), 32'd8);
    chk_eq("fill_cmd",   32'(cmd_count),  32'd4);
    send_ui(14'h0006, 1'b1);
    chk_eq("ovf_cnt",    32'(ovf_count),  32'd1);
    chk_eq("ovf_level",  32'(fifo_level), 32'd8);
    chk_eq("ovf_sticky", 32'(err_sticky), 32'd1);
    chk_eq("ovf_head",   32'(ca_if.ca_out), 32'h0010);
    // full FIFO, but the same-cycle pop makes room
    ca_if.ca_ready_in = 1'b1;
    send_ui(14'h000A, 1'b1);
    chk_eq("pop_level", 32'(fifo_level), 32'd8);
    chk_eq("pop_cmd",   32'(cmd_count),  32'd5);
    chk_eq("pop_ovf",   32'(ovf_count),  32'd1);
    for (int i = 1; i < 8; i++) begin
      chk_eq($sformatf("drain_ca%0d", i), 32'(ca_if.ca_out), 32'(exp_q[i][CAW-1:0]));
      chk_eq($sformatf("drain_last%0d", i), 32'(ca_if.ca_last_out), 32'(exp_q[i][CAW]));
      tick();
    end
    chk_eq("drain_tail",  32'(ca_if.ca_out),      32'h000A);
    chk_eq("drain_tlast", 32'(ca_if.ca_last_out), 32'd1);
    tick();
    chk_eq("drain_empty", 32'(fifo_level), 32'd0);

    // ---------------- abort via enable ----------------
    ca_if.ca_ready_in = 1'b0;
    send_ui(14'h1000, 1'b1);
    enable = 1'b0;
    send_ui(14'h0555, 1'b1);
    enable = 1'b1;
    tick();
    chk_eq("abort_level", 32'(fifo_level),    32'd0);
    chk_eq("abort_cmd",   32'(cmd_count),     32'd5);
    chk_eq("abort_par",   32'(par_err_count), 32'd0);
    chk_eq("abort_ovf",   32'(ovf_count),     32'd1);

    // ---------------- err_clr coincident with a parity drop ----------------
    err_clr = 1'b1;
    send_ui(14'h0002, 1'b0);
    err_clr = 1'b0;
    chk_eq("clrpar_par",    32'(par_err_count), 32'd1);
    chk_eq("clrpar_sticky", 32'(err_sticky),    32'd1);
    chk_eq("clrpar_ovf",    32'(ovf_count),     32'd0);
    chk_eq("clrpar_cmd",    32'(cmd_count),     32'd0);

    // ---------------- async reset with entries queued ----------------
    send_ui(14'h0002, 1'b1);
    send_ui(14'h0006, 1'b1);
    send_ui(14'h000E, 1'b1);
    chk_eq("q3_level", 32'(fifo_level), 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_eq("arst_valid", 32'(ca_if.ca_valid_out), 32'd0);
    chk_eq("arst_level", 32'(fifo_level),         32'd0);
    chk_eq("arst_cmd",   32'(cmd_count),          32'd0);
    tick();
    rst_n = 1'b1;
    ca_if.ca_ready_in = 1'b1;
    tick();
    tick();
    chk_eq("post_valid", 32'(ca_if.ca_valid_out), 32'd0);
    chk_eq("post_level", 32'(fifo_level),         32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ca_cmd_framer.md
Name: ca_cmd_framer

Overview:
- Upstream front-end of the CA distributor.
- Samples the host-side DDR5 CA bus (DCS_n, DCA, DPAR) every clk and frames 1-UI and 2-UI commands.
- Checks parity and holds the first UI of a 2-UI command until its second UI arrives, so only complete, parity-clean commands are committed.
- Buffers committed UIs in a FWFT FIFO that drives the distributor's valid/ready CA input, one CA word per beat plus a last-UI flag.

Parameters:
- CA_WIDTH, 14, width of one CA UI word; must match the distributor.
- FIFO_DEPTH, 8, entries in the UI FIFO; power of 2, minimum 4.
- CNT_WIDTH, 16, width of the saturating status counters.

Ports:
- clk  input  1  core clock, one CA UI per cycle.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  framer enable; low means idle and abort any in-flight command.
- par_chk_en  input  1  enables parity checking.
- dcs_n  input  1  host chip select, active-low; marks the first UI of a command.
- dca  input  CA_WIDTH  host CA UI.
- dpar  input  1  host parity for dca.
- ca_out  output  CA_WIDTH  FIFO head UI to the distributor.
- ca_last_out  output  1  head UI is the final UI of its command.
- ca_valid_out  output  1  head valid (FIFO non-empty).
- ca_ready_in  input  1  distributor accepts the head UI.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current occupancy.
- cmd_count  output  CNT_WIDTH  committed commands, saturating.
- par_err_count  output  CNT_WIDTH  commands dropped for parity, saturating.
- ovf_count  output  CNT_WIDTH  commands dropped for FIFO space, saturating.
- err_sticky  output  1  set on any parity or overflow drop.
- err_clr  input  1  synchronous clear of err_sticky and all three counters.

Behaviour:
- Reset (async): FSM IDLE, FIFO empty, holding register 0. Outputs: ca_out=0, ca_last_out=0, ca_valid_out=0, fifo_level=0, all counters 0, err_sticky=0.
- Parity: a UI is good when XOR of {dca, dpar} = 0 (even parity). With par_chk_en=0 every UI is good.
- Command length is decoded from the first UI: dca[1]=1 is a 1-UI command, dca[1]=0 is a 2-UI command.
- FSM IDLE (enable=1, dcs_n=0):
  - 1-UI command: commit if parity is good and at least 1 entry is free. Write the UI with last=1 and increment cmd_count; stay IDLE.
  - 2-UI command: latch the UI and its parity-good bit into the holding register; go to SECOND.
- FSM IDLE with dcs_n=1 or enable=0: no action.
- FSM SECOND (next cycle, dcs_n ignored, enable=1):
  - Commit if both UIs are good and at least 2 entries are free.
  - Commit writes the held UI (last=0) and the current UI (last=1) in the same cycle, in that order; cmd_count increments.
  - Go to IDLE regardless of outcome; a new command can start on the following cycle.
- SECOND with enable=0: discard the held UI, go to IDLE, no counter change.
- Drop rules:
  - Parity failure on either UI: drop the whole command, par_err_count+1, err_sticky=1.
  - Parity is good but space is insufficient: drop the whole command, ovf_count+1, err_sticky=1.
  - Parity failure takes precedence over overflow; exactly one counter increments per dropped command.
  - A partial command is never written.
- Free space is computed as FIFO_DEPTH - fifo_level + (pop this cycle ? 1 : 0). A same-cycle pop frees space for the write.
- FIFO is first-word fall-through. Pop occurs when ca_valid_out && ca_ready_in.
  - ca_out and ca_last_out are stable while valid && !ready.
- Latency: a UI committed at edge N appears at ca_out after edge N (visible cycle N+1). For a 2-UI command, the first UI is visible the cycle after the second UI is sampled.
- Simultaneous push and pop: fifo_level changes by (pushes - pops). The level never exceeds FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by fifo_level.
- Counters saturate at all-ones.
- err_clr: clears err_sticky and all three counters that cycle. An error or commit in the same cycle wins and loads 1 (counter=1, err_sticky=1).
- Reset asserted mid-command or with data in the FIFO: flush everything immediately; no output is produced after reset release until a new command is committed.

Test Plan:
- 1-UI command: dcs_n=0, dca=0x0002, good parity, ca_ready_in=1 -> ca_valid_out=1 next cycle with ca_out=0x0002, ca_last_out=1; cmd_count=1.
- 2-UI command: UI0=0x1000 (dca[1]=0), then UI1=0x2ABC -> cycle after UI1, ca_out=0x1000 (last=0) then 0x2ABC (last=1) on consecutive cycles; cmd_count=1.
- Parity error: par_chk_en=1, bad dpar on UI1 of a 2-UI command -> nothing written, par_err_count=1, err_sticky=1. Repeat with par_chk_en=0 -> command committed.
- Backpressure/overflow: ca_ready_in=0, send 4 2-UI commands at FIFO_DEPTH=8 (level=8), then a 1-UI command -> dropped, ovf_count=1, level stays 8. Then raise ready while a new 1-UI arrives at level=8 -> accepted via same-cycle pop.
- Abort and reset: UI0 of a 2-UI command then enable=0 -> no write, no counters. Assert rst_n low with 3 entries queued -> ca_valid_out=0, fifo_level=0 immediately.
- err_clr: with counts non-zero, pulse err_clr -> all counters 0 and err_sticky=0. err_clr coincident with a parity drop -> par_err_count=1, err_sticky=1.
